// File: rtl/mdu_if.sv
// Controller-to-MDU interface: operation issue, HI/LO access and status back to the hazard unit.
interface mdu_if;
  logic        start;
  logic [2:0]  multctrl;
  logic [1:0]  muwe;
  logic [1:0]  mure;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  modport master (
    output start, multctrl, muwe, mure, cancel, a, b,
    input  busy, stall_req, hi, lo, out
  );

  modport slave (
    input  start, multctrl, muwe, mure, cancel, a, b,
    output busy, stall_req, hi, lo, out
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at issue and held
// pending until the cycle count expires, so the latency is purely a timing model.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset_n,
  mdu_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]  state_q;
  logic [7:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_commit_q;

  logic [31:0] a, b;
  logic        op_valid, is_mult, is_div, div_by_zero, issue, mt_write;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  assign a = bus.a;
  assign b = bus.b;

  assign op_valid    = (bus.multctrl >= 3'd1) && (bus.multctrl <= 3'd4);
  assign is_mult     = (bus.multctrl == 3'd1) || (bus.multctrl == 3'd2);
  assign is_div      = (bus.multctrl == 3'd3) || (bus.multctrl == 3'd4);
  assign div_by_zero = (b == 32'd0);
  assign issue       = (state_q == StIdle) && bus.start && !bus.cancel && op_valid;
  // A start of any kind takes priority over an mthi/mtlo in the same cycle.
  assign mt_write    = (state_q == StIdle) && !bus.start && !bus.cancel;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide done on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN rem 0.
  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = div_by_zero ? 32'd1 : (b[31] ? (~b + 32'd1) : b);
  assign div_b = div_by_zero ? 32'd1 : b;
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign q_u   = a / div_b;
  assign r_u   = a % div_b;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (bus.multctrl)
      3'd1: {res_hi, res_lo} = prod_s;
      3'd2: {res_hi, res_lo} = prod_u;
      3'd3: begin
        res_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        res_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
      end
      3'd4: begin
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      pend_hi_q     <= 32'd0;
      pend_lo_q     <= 32'd0;
      pend_commit_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (issue) begin
        state_q       <= StRun;
        cnt_q         <= is_mult ? 8'(MULT_CYCLES - 1) : 8'(DIV_CYCLES - 1);
        pend_hi_q     <= res_hi;
        pend_lo_q     <= res_lo;
        pend_commit_q <= !(is_div && div_by_zero);
      end else if (mt_write) begin
        if (bus.muwe == 2'd1) hi_q <= a;
        if (bus.muwe == 2'd2) lo_q <= a;
      end
    end else begin
      if (cnt_q == 8'd0) begin
        state_q <= StIdle;
        if (pend_commit_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.stall_req = bus.start | bus.busy;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.out       = (bus.mure == 2'd1) ? hi_q : (bus.mure == 2'd2) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, arithmetic, HI/LO moves, cancel and async reset.
module tb_mdu_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] m_hi, m_lo;

  mdu_if bus ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [31:0] av,
                        input logic [31:0] bv, input int cyc, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    bus.a = av; bus.b = bv; bus.multctrl = ctrl; bus.start = 1'b1;
    #1;
    check({tag, "_stall"}, {31'd0, bus.stall_req}, 32'd1);
    tick();
    bus.start = 1'b0; bus.multctrl = 3'd0;
    n = 0;
    while (bus.busy && n < 40) begin
      if (n == 1) check({tag, "_old_hi"}, bus.hi, m_hi);
      n++;
      tick();
    end
    check({tag, "_cycles"}, 32'(n), 32'(cyc));
    check({tag, "_hi"}, bus.hi, ehi);
    check({tag, "_lo"}, bus.lo, elo);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.multctrl = 3'd0; bus.muwe = 2'd0; bus.mure = 2'd0;
    bus.cancel = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    bus.mure = 2'd1; #1 check("mfhi", bus.out, 32'h0000_0001);
    bus.mure = 2'd2; #1 check("mflo", bus.out, 32'hFFFF_FFFE);
    bus.mure = 2'd3; #1 check("mure3", bus.out, 32'd0);
    bus.mure = 2'd0;

    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    run_op("div_mix", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);

    bus.muwe = 2'd1; bus.a = 32'h1234; tick();
    check("mthi", bus.hi, 32'h1234);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.muwe = 2'd2; bus.a = 32'h5678; tick();
    bus.muwe = 2'd0;
    check("mtlo", bus.lo, 32'h5678);
    check("mtlo_hi", bus.hi, 32'h1234);
    m_hi = 32'h1234; m_lo = 32'h5678;
    run_op("divu0", 3'd4, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

    bus.cancel = 1'b1; bus.start = 1'b1; bus.multctrl = 3'd1; bus.a = 32'd5; bus.b = 32'd5;
    tick();
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0; bus.multctrl = 3'd0; bus.muwe = 2'd1; bus.a = 32'hDEAD;
    tick();
    bus.cancel = 1'b0; bus.muwe = 2'd0;
    check("cancel_mthi", bus.hi, 32'h1234);
    check("cancel_lo", bus.lo, 32'h5678);
    bus.start = 1'b1; bus.multctrl = 3'd6;
    tick();
    bus.start = 1'b0; bus.multctrl = 3'd0;
    check("bad_ctrl_busy", {31'd0, bus.busy}, 32'd0);
    check("bad_ctrl_hi", bus.hi, 32'h1234);

    // Second start lands two cycles into a mult and must be dropped.
    bus.a = 32'd3; bus.b = 32'd4; bus.multctrl = 3'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.multctrl = 3'd0;
    n = 0;
    while (bus.busy && n < 40) begin
      if (n == 2) begin
        bus.start = 1'b1; bus.multctrl = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
      end else begin
        bus.start = 1'b0; bus.multctrl = 3'd0;
      end
      n++;
      tick();
    end
    bus.start = 1'b0; bus.multctrl = 3'd0;
    check("midrun_cycles", 32'(n), 32'd5);
    check("midrun_hi", bus.hi, 32'd0);
    check("midrun_lo", bus.lo, 32'd12);
    tick();
    check("midrun_idle", {31'd0, bus.busy}, 32'd0);

    bus.a = 32'hFFFF_FFF9; bus.b = 32'd2; bus.multctrl = 3'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.multctrl = 3'd0;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (12) tick();
    check("arst_nocommit_lo", bus.lo, 32'd0);
    check("arst_nocommit_hi", bus.hi, 32'd0);
    check("arst_idle", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
